// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch and load/store) in front of one
// single-port memory. D has fixed priority; a starvation counter forces an IF
// grant after STARVE_LIMIT consecutive D grants while IF was waiting.
// Every transaction goes IDLE -> BUSY_x -> IDLE, so there is always one bubble
// cycle between accesses. All outputs are registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction fetch requester
  input  logic                  if_req_i,
  input  logic [ADDR_W-1:0]     if_addr_i,
  output logic [DATA_W-1:0]     if_rdata_o,
  output logic                  if_ready_o,
  // Load/store requester
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_W-1:0]     d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  d_ready_o,
  // Memory side
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q,    mem_be_d;
  logic                if_ready_q,  if_ready_d;
  logic                d_ready_q,   d_ready_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;

  logic starve_hit_c;
  logic grant_d_c;
  logic grant_if_c;

  // IF has waited through the maximum number of back-to-back D grants.
  assign starve_hit_c = (cnt_q == CNT_W'(STARVE_LIMIT));

  // D wins unless IF is waiting and has been starved; IF takes what is left.
  assign grant_d_c  = d_req_i && !(if_req_i && starve_hit_c);
  assign grant_if_c = if_req_i && !grant_d_c;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Arbitration in IDLE, completion handling in BUSY_x.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_d_c) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          mem_be_d    = d_be_i;
          // Count D grants only while IF is actually waiting.
          if (!if_req_i) begin
            cnt_d = '0;
          end else if (!starve_hit_c) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (grant_if_c) begin
          state_d     = ST_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          cnt_d       = '0;
        end
      end
      ST_BUSY_IF: begin
        if (mem_ack_i) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          if_ready_d = 1'b1;
          if_rdata_d = mem_rdata_i;
        end
      end
      ST_BUSY_D: begin
        if (mem_ack_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          d_ready_d = 1'b1;
          // Stores leave the last load value in place.
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata_i;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;
  assign if_ready_o  = if_ready_q;
  assign d_ready_o   = d_ready_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between two requesters: instruction fetch (IF) and the load/store path (D).
- Sits between the core's fetch/LSU logic and the external memory interface.
- Registered FSM with a request/ack handshake on the memory side and req/ready on each requester.
- D has fixed priority, with a starvation limiter that guarantees IF forward progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, maximum consecutive D grants while IF is waiting; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF read request; held until if_ready.
- if_addr  in  ADDR_W  IF read address.
- if_rdata  out  DATA_W  fetched word, valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- d_req  in  1  D request; held until d_ready.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data, valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for D.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion; arrives no earlier than 1 cycle after mem_req rises.

Behaviour:
- Reset (async): FSM to IDLE; starve_cnt=0. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, d_ready, if_rdata, d_rdata.
- All outputs are registered.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE arbitration, per cycle:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant D, unless starve_cnt==STARVE_LIMIT, in which case grant IF.
  - On grant, latch address (plus we/wdata/be for D) into mem_* and set mem_req=1 next cycle.
  - For IF grants, force mem_we=0 and mem_be=all-ones.
- BUSY_x:
  - mem_req and mem_* stay stable until mem_ack.
  - On the mem_ack cycle: next cycle mem_req=0, the x_ready pulse=1 for exactly one cycle, and the FSM returns to IDLE.
  - On loads/fetches, x_rdata captures mem_rdata.
  - On stores, d_ready pulses and d_rdata holds its previous value.
- One-cycle bubble: IDLE is always visited between transactions. Minimum turnaround is req→mem_req 1 cycle, mem_ack→ready 1 cycle.
- x_rdata holds its value until the next completion for that requester.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments on a D grant while if_req=1.
  - Clears on any IF grant.
  - Clears on a D grant while if_req=0.
  - Saturates at STARVE_LIMIT.
- Requesters must hold req and payload stable until ready. A req deassertion mid-transaction does not abort it; the transaction completes and ready still pulses.
- The arbiter samples x_req in IDLE only. A req still high in the cycle its ready pulses is treated as a new request: ready pulses in the IDLE cycle, so the requester must drop req that same cycle unless it wants another access.
- mem_ack outside BUSY states is ignored.
- Async reset mid-transaction: mem_req drops immediately, no ready pulse is produced, and the in-flight memory access is abandoned. The memory side must tolerate this.

Test Plan:
- IF only: if_req=1 with if_addr=0x100. Expect mem_req=1 and mem_addr=0x100 at cycle 1. mem_ack with mem_rdata=0xDEADBEEF at cycle 3 gives if_ready=1 and if_rdata=0xDEADBEEF at cycle 4, and mem_req=0 at cycle 4.
- Store: d_req=1, d_we=1, d_addr=0x2004, d_wdata=0x11223344, d_be=4'b0011. Expect mem_we=1 and mem_be=0011 until ack; d_ready pulses one cycle; d_rdata is unchanged.
- Simultaneous if_req and d_req with STARVE_LIMIT=4, D re-requesting continuously, 1-cycle memory ack: grant order is D,D,D,D,IF,D…
  - The IF grant is observed on the 5th transaction.
  - starve_cnt returns to 0 after the IF grant.
- mem_ack held high while in IDLE with no requests: no ready pulse, mem_req stays 0, state stays IDLE.
- rst asserted in BUSY_D, mid-transaction: mem_req, d_ready and if_ready are 0 in the same cycle (async). After release, if_req alone is granted normally.
- Requester drops d_req after grant, before ack: transaction completes and d_ready pulses once. No second transaction is issued.
